// File: rtl/hps_reset_sequencer.sv
// Turns ISSP cold/warm/debug request edges into timed f2h reset-request pulses and tracks the HPS handshake.
// Optional macro HPS_RESET_SEQ_PENDING_EN queues requests that arrive while a sequence is running.
module hps_reset_sequencer #(
    parameter int PULSE_CYCLES       = 16,
    parameter int ACK_TIMEOUT_CYCLES = 65536,
    parameter int GUARD_CYCLES       = 64
) (
    input  logic       piul1Clock,
    input  logic       piul1Reset,
    input  logic [2:0] piul3Request,
    input  logic       piul1HpsResetN,
    output logic       poul1ColdReqN,
    output logic       poul1WarmReqN,
    output logic       poul1DbgReqN,
    output logic       poul1Busy,
    output logic [1:0] poul2LastKind,
    output logic       poul1Timeout,
    output logic [7:0] poul8DoneCount,
    output logic       poul1Probe
);

    localparam int MAX_PT = (PULSE_CYCLES > ACK_TIMEOUT_CYCLES) ? PULSE_CYCLES : ACK_TIMEOUT_CYCLES;
    localparam int MAX_C  = (MAX_PT > GUARD_CYCLES) ? MAX_PT : GUARD_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ASSERT    = 3'd1;
    localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd3;
    localparam logic [2:0] ST_GUARD     = 3'd4;

    localparam logic [1:0] KIND_COLD = 2'd1;
    localparam logic [1:0] KIND_WARM = 2'd2;
    localparam logic [1:0] KIND_DBG  = 2'd3;

    logic [2:0]    req_q;
    logic [2:0]    req_prev;
    logic [2:0]    edges;
    logic [2:0]    arb;
    logic [1:0]    sel_kind;
    logic          hps_s1;
    logic          hps_s2;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    last_kind;
    logic          timeout_q;
    logic [7:0]    done_cnt;

    assign edges = req_q & ~req_prev;

`ifdef HPS_RESET_SEQ_PENDING_EN
    logic [2:0] pending;
    logic [2:0] pending_nxt;
    logic [2:0] sel_bit;

    always_comb begin
        arb         = pending | edges;
        sel_bit     = {arb[2] & ~(|arb[1:0]), arb[1] & ~arb[0], arb[0]};
        pending_nxt = pending | edges;
        if (state == ST_IDLE) begin
            pending_nxt = arb & ~sel_bit;
        end
    end

    always_ff @(posedge piul1Clock) begin
        if (piul1Reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end
`else
    assign arb = edges;
`endif

    always_comb begin
        sel_kind = 2'd0;
        if (arb[0]) begin
            sel_kind = KIND_COLD;
        end else if (arb[1]) begin
            sel_kind = KIND_WARM;
        end else if (arb[2]) begin
            sel_kind = KIND_DBG;
        end
    end

    // last_kind doubles as the kind of the sequence in progress
    always_ff @(posedge piul1Clock) begin
        if (piul1Reset) begin
            req_q     <= piul3Request;
            req_prev  <= piul3Request;
            hps_s1    <= 1'b1;
            hps_s2    <= 1'b1;
            state     <= ST_IDLE;
            cnt       <= '0;
            last_kind <= '0;
            timeout_q <= 1'b0;
            done_cnt  <= '0;
        end else begin
            req_q    <= piul3Request;
            req_prev <= req_q;
            hps_s1   <= piul1HpsResetN;
            hps_s2   <= hps_s1;
            case (state)
                ST_IDLE: begin
                    if (arb != 3'b000) begin
                        state     <= ST_ASSERT;
                        cnt       <= '0;
                        last_kind <= sel_kind;
                    end
                end
                ST_ASSERT: begin
                    if (cnt == PULSE_LAST) begin
                        cnt <= '0;
                        if (last_kind == KIND_DBG) begin
                            state    <= ST_GUARD;
                            done_cnt <= done_cnt + 8'd1;
                        end else begin
                            state <= ST_WAIT_LOW;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!hps_s2) begin
                        state <= ST_WAIT_HIGH;
                        cnt   <= cnt + 1'b1;
                    end else if (cnt == ACK_LAST) begin
                        state     <= ST_GUARD;
                        timeout_q <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    // cnt may sit one past ACK_LAST if the low phase ended on the last window cycle
                    if (hps_s2) begin
                        state    <= ST_GUARD;
                        done_cnt <= done_cnt + 8'd1;
                        cnt      <= '0;
                    end else if (cnt >= ACK_LAST) begin
                        state     <= ST_GUARD;
                        timeout_q <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GUARD: begin
                    if (cnt == GUARD_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign poul1Busy      = (state != ST_IDLE);
    assign poul1ColdReqN  = ~((state == ST_ASSERT) && (last_kind == KIND_COLD));
    assign poul1WarmReqN  = ~((state == ST_ASSERT) && (last_kind == KIND_WARM));
    assign poul1DbgReqN   = ~((state == ST_ASSERT) && (last_kind == KIND_DBG));
    assign poul2LastKind  = last_kind;
    assign poul1Timeout   = timeout_q;
    assign poul8DoneCount = done_cnt;
    assign poul1Probe     = poul1Busy | timeout_q;

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// Self-checking bench for hps_reset_sequencer: directed scenarios plus randomized HPS handshakes
// checked against a cycle-window reference model.
module tb_hps_reset_sequencer;

    localparam int P = 4;
    localparam int T = 32;
    localparam int G = 8;
    localparam int N = 64;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic       hps;
    logic       cold_n, warm_n, dbg_n, busy, tmo, probe;
    logic [1:0] kind;
    logic [7:0] done;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_done = 0;
    int exp_kind = 0;
    int exp_to   = 0;

    hps_reset_sequencer #(
        .PULSE_CYCLES(P),
        .ACK_TIMEOUT_CYCLES(T),
        .GUARD_CYCLES(G)
    ) dut (
        .piul1Clock(clk),
        .piul1Reset(rst),
        .piul3Request(req),
        .piul1HpsResetN(hps),
        .poul1ColdReqN(cold_n),
        .poul1WarmReqN(warm_n),
        .poul1DbgReqN(dbg_n),
        .poul1Busy(busy),
        .poul2LastKind(kind),
        .poul1Timeout(tmo),
        .poul8DoneCount(done),
        .poul1Probe(probe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // one cycle: drive after the rising edge, caller samples after the falling edge
    task automatic step(input logic [2:0] r, input logic h, input logic rs);
        @(posedge clk);
        #1;
        req = r;
        hps = h;
        rst = rs;
        @(negedge clk);
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_done"}, int'(done), exp_done);
        chk({tag, "_kind"}, int'(kind), exp_kind);
        chk({tag, "_timeout"}, int'(tmo), exp_to);
        chk({tag, "_probe"}, int'(probe), int'(busy) | exp_to);
    endtask

    // One sequence window of N cycles; request level held for cycles 0..2, HPS low for [l0, l0+dur).
    task automatic run_scn(input string tag, input logic [2:0] mask, input int l0, input int dur, input bit stuck);
        logic        h [N];
        logic [63:0] ob_c, ob_w, ob_d, ob_b;
        logic [63:0] ex_c, ex_w, ex_d, ex_b;
        logic [2:0]  rem;
        int          ki, a, w, g, j, m, lim, s;
        logic        s2;
        ob_c = '0; ob_w = '0; ob_d = '0; ob_b = '0;
        ex_c = '0; ex_w = '0; ex_d = '0; ex_b = '0;
        for (int n = 0; n < N; n++) h[n] = stuck ? 1'b1 : !(n >= l0 && n < l0 + dur);
        for (int n = 0; n < N; n++) begin
            step((n < 3) ? mask : 3'b000, h[n], 1'b0);
            ob_c[n] = !cold_n;
            ob_w[n] = !warm_n;
            ob_d[n] = !dbg_n;
            ob_b[n] = busy;
        end
        // reference: edge seen in cycle 1, pulse cycles 2..P+1, then handshake window from cycle P+2
        ki  = mask[0] ? 0 : (mask[1] ? 1 : 2);
        rem = mask & ~(3'b001 << ki);
        a   = 2;
        w   = a + P;
        if (ki == 2) begin
            g = w;
            exp_done = (exp_done + 1) % 256;
        end else begin
            j = -1;
            for (int c = 0; c < T; c++) begin
                s2 = (w + c - 2 < 0) ? 1'b1 : h[w + c - 2];
                if (j < 0 && !s2) j = c;
            end
            if (j < 0) begin
                exp_to = 1;
                g = w + T;
            end else begin
                lim = (j + 1 > T - 1) ? j + 1 : T - 1;
                m = -1;
                for (int c = j + 1; c <= lim; c++) begin
                    s2 = h[w + c - 2];
                    if (m < 0 && s2) m = c;
                end
                if (m >= 0) begin
                    exp_done = (exp_done + 1) % 256;
                    g = w + m + 1;
                end else begin
                    exp_to = 1;
                    g = w + lim + 1;
                end
            end
        end
        exp_kind = ki + 1;
        for (int n = a; n < a + P; n++) begin
            if (ki == 0) ex_c[n] = 1'b1;
            else if (ki == 1) ex_w[n] = 1'b1;
            else ex_d[n] = 1'b1;
        end
        for (int n = a; n < g + G; n++) ex_b[n] = 1'b1;
`ifdef HPS_RESET_SEQ_PENDING_EN
        if (rem[2]) begin
            s = g + G + 1;
            for (int n = s; n < s + P; n++) ex_d[n] = 1'b1;
            for (int n = s; n < s + P + G; n++) ex_b[n] = 1'b1;
            exp_done = (exp_done + 1) % 256;
            exp_kind = 3;
        end
`else
        s = rem[2] ? 1 : 0;
`endif
        chk64({tag, "_coldlow"}, ob_c, ex_c);
        chk64({tag, "_warmlow"}, ob_w, ex_w);
        chk64({tag, "_dbglow"}, ob_d, ex_d);
        chk64({tag, "_busy"}, ob_b, ex_b);
        chk_status(tag);
    endtask

    initial begin
        int lo_cnt;
        int rsel;
        rst = 1'b1;
        req = 3'b010;
        hps = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cold_n", int'(cold_n), 1);
        chk("rst_warm_n", int'(warm_n), 1);
        chk("rst_dbg_n", int'(dbg_n), 1);
        chk("rst_busy", int'(busy), 0);
        chk_status("rst");

        // warm level already high through reset must not start a sequence
        lo_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            step(3'b010, 1'b1, 1'b0);
            if (!warm_n || busy) lo_cnt++;
        end
        chk("held_at_reset_activity", lo_cnt, 0);
        repeat (4) step(3'b000, 1'b1, 1'b0);

        run_scn("cold", 3'b001, 4, 10, 1'b0);
        run_scn("debug", 3'b100, 0, 0, 1'b1);
        run_scn("warm_dbg", 3'b110, 6, 5, 1'b0);
        if (exp_to == 0) run_scn("warm", 3'b010, 10, 3, 1'b0);

        for (int i = 0; i < 14; i++) begin
            rsel = $urandom_range(0, 2);
            run_scn($sformatf("rand%0d", i), 3'b001 << rsel,
                    $urandom_range(0, 40), $urandom_range(1, 15), ($urandom_range(0, 6) == 0));
        end

        run_scn("stuck_high", 3'b001, 0, 0, 1'b1);
        chk("stuck_timeout", int'(tmo), 1);

        // debug held high for 100 cycles is served exactly once
        lo_cnt = 0;
        for (int n = 0; n < 100; n++) begin
            step(3'b100, 1'b1, 1'b0);
            if (!dbg_n) lo_cnt++;
        end
        repeat (10) step(3'b000, 1'b1, 1'b0);
        exp_done = (exp_done + 1) % 256;
        exp_kind = 3;
        chk("held100_dbglow", lo_cnt, P);
        chk_status("held100");

        // 256 debug sequences bring the counter back to where it started
        for (int i = 0; i < 256; i++) begin
            step(3'b100, 1'b1, 1'b0);
            step(3'b100, 1'b1, 1'b0);
            repeat (18) step(3'b000, 1'b1, 1'b0);
            if (i == 127) chk("wrap_half", int'(done), (exp_done + 128) % 256);
        end
        chk_status("wrap256");

        // reset while the cold pulse is being driven
        step(3'b001, 1'b1, 1'b0);
        step(3'b001, 1'b1, 1'b0);
        step(3'b001, 1'b1, 1'b0);
        chk("midrst_pre_cold_n", int'(cold_n), 0);
        step(3'b001, 1'b1, 1'b1);
        chk("midrst_before_edge_cold_n", int'(cold_n), 0);
        step(3'b001, 1'b1, 1'b0);
        exp_done = 0;
        exp_kind = 0;
        exp_to   = 0;
        chk("midrst_cold_n", int'(cold_n), 1);
        chk("midrst_busy", int'(busy), 0);
        chk_status("midrst");
        lo_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            step(3'b001, 1'b1, 1'b0);
            if (!cold_n || busy) lo_cnt++;
        end
        chk("midrst_after_activity", lo_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
